// File: rtl/axi_pkg.sv
// Shared AXI read-channel constants and the arbiter FSM state type.
package axi_pkg;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_LEN_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request selector: round-robin from a pointer, or fixed lowest-index priority.
module rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  input  logic                   mode,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx
);

  logic        found;
  int unsigned idx;

  // Walk candidates starting at the pointer (or at 0 in fixed mode); first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      idx = mode ? k : (int'(ptr) + k) % NUM_MASTERS;
      if (!found && ((req & (NUM_MASTERS'(1) << idx)) != '0)) begin
        found     = 1'b1;
        grant     = NUM_MASTERS'(1) << idx;
        grant_idx = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// AXI4 read-channel arbiter: NUM_MASTERS AR/R ports share one memory port, one burst in flight.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ARB_MODE    = 0,
  localparam int unsigned IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            s_arvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     s_araddr,
  input  logic [NUM_MASTERS*AXI_BURST_W-1:0] s_arburst,
  input  logic [NUM_MASTERS*AXI_SIZE_W-1:0] s_arsize,
  input  logic [NUM_MASTERS*AXI_LEN_W-1:0]  s_arlen,
  output logic [NUM_MASTERS-1:0]            s_arready,
  output logic [NUM_MASTERS-1:0]            s_rvalid,
  output logic [DATA_W-1:0]                 s_rdata,
  output logic                              s_rlast,
  input  logic [NUM_MASTERS-1:0]            s_rready,
  output logic                              m_arvalid,
  output logic [ADDR_W-1:0]                 m_araddr,
  output logic [AXI_BURST_W-1:0]            m_arburst,
  output logic [AXI_SIZE_W-1:0]             m_arsize,
  output logic [AXI_LEN_W-1:0]              m_arlen,
  input  logic                              m_arready,
  input  logic                              m_rvalid,
  input  logic [DATA_W-1:0]                 m_rdata,
  input  logic                              m_rlast,
  output logic                              m_rready,
  output logic                              busy,
  output logic [IDX_W-1:0]                  grant_id,
  output logic                              err_len
);

  arb_state_e               state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, gid_q, gidx;
  logic [NUM_MASTERS-1:0]   grant;
  logic [ADDR_W-1:0]        addr_q, sel_addr;
  logic [AXI_BURST_W-1:0]   burst_q, sel_burst;
  logic [AXI_SIZE_W-1:0]    size_q, sel_size;
  logic [AXI_LEN_W-1:0]     len_q, sel_len, cnt_q;
  logic                     err_q;
  logic                     take;
  logic                     beat;

  rr_arbiter #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_sel (
    .req       (s_arvalid),
    .ptr       (ptr_q),
    .mode      (ARB_MODE != 0),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_burst = '0;
    sel_size  = '0;
    sel_len   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant[i]) begin
        sel_addr  = s_araddr[i*ADDR_W +: ADDR_W];
        sel_burst = s_arburst[i*AXI_BURST_W +: AXI_BURST_W];
        sel_size  = s_arsize[i*AXI_SIZE_W +: AXI_SIZE_W];
        sel_len   = s_arlen[i*AXI_LEN_W +: AXI_LEN_W];
      end
    end
  end

  assign take = (state_q == IDLE) && (s_arvalid != '0);
  assign beat = (state_q == DATA) && m_rvalid && m_rready;

  always_comb begin
    state_d   = state_q;
    s_arready = '0;
    s_rvalid  = '0;
    s_rdata   = '0;
    s_rlast   = 1'b0;
    m_rready  = 1'b0;
    m_arvalid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Gated by rst so the asynchronous reset holds every output at 0.
        s_arready = grant & {NUM_MASTERS{!rst}};
        if (s_arvalid != '0) state_d = ADDR;
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = DATA;
      end
      DATA: begin
        s_rvalid = NUM_MASTERS'(m_rvalid) << gid_q;
        m_rready = |(s_rready & (NUM_MASTERS'(1) << gid_q));
        s_rdata  = m_rdata;
        s_rlast  = m_rlast;
        if (m_rvalid && m_rready && m_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      size_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        gid_q   <= gidx;
        addr_q  <= sel_addr;
        burst_q <= sel_burst;
        size_q  <= sel_size;
        len_q   <= sel_len;
        cnt_q   <= '0;
      end
      if ((state_q == ADDR) && m_arready)
        ptr_q <= (gid_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : gid_q + 1'b1;
      // Compare uses the pre-increment count so a 256-beat burst checks before wrapping.
      if (beat) begin
        cnt_q <= cnt_q + 1'b1;
        if ((m_rlast && (cnt_q != len_q)) || (!m_rlast && (cnt_q == len_q)))
          err_q <= 1'b1;
      end
    end
  end

  assign m_araddr  = addr_q;
  assign m_arburst = burst_q;
  assign m_arsize  = size_q;
  assign m_arlen   = len_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = gid_q;
  assign err_len   = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: burst table, contention/reset sequences, randomized run vs transaction model.
module tb_axi_rd_arbiter;
  import axi_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
  localparam int unsigned GW = 2;

  logic            clk, rst;
  logic [N-1:0]    s_arvalid, s_rready;
  logic [N*AW-1:0] s_araddr;
  logic [N*2-1:0]  s_arburst;
  logic [N*3-1:0]  s_arsize;
  logic [N*8-1:0]  s_arlen;
  logic            m_arready, m_rvalid, m_rlast;
  logic [DW-1:0]   m_rdata;

  logic [N-1:0]  s_arready, s_rvalid, fp_s_arready, fp_s_rvalid;
  logic [DW-1:0] s_rdata, fp_s_rdata;
  logic          s_rlast, fp_s_rlast, m_arvalid, fp_m_arvalid, m_rready, fp_m_rready;
  logic [AW-1:0] m_araddr, fp_m_araddr;
  logic [1:0]    m_arburst, fp_m_arburst;
  logic [2:0]    m_arsize, fp_m_arsize;
  logic [7:0]    m_arlen, fp_m_arlen;
  logic          busy, fp_busy, err_len, fp_err_len;
  logic [GW-1:0] grant_id, fp_grant_id;

  int vectors = 0;
  int miscompares = 0;

  axi_rd_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst), .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arburst(s_arburst),
    .s_arsize(s_arsize), .s_arlen(s_arlen), .s_arready(s_arready), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rready(s_rready), .m_arvalid(m_arvalid),
    .m_araddr(m_araddr), .m_arburst(m_arburst), .m_arsize(m_arsize), .m_arlen(m_arlen),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rready(m_rready), .busy(busy), .grant_id(grant_id), .err_len(err_len));

  axi_rd_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst), .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arburst(s_arburst),
    .s_arsize(s_arsize), .s_arlen(s_arlen), .s_arready(fp_s_arready), .s_rvalid(fp_s_rvalid),
    .s_rdata(fp_s_rdata), .s_rlast(fp_s_rlast), .s_rready(s_rready), .m_arvalid(fp_m_arvalid),
    .m_araddr(fp_m_araddr), .m_arburst(fp_m_arburst), .m_arsize(fp_m_arsize), .m_arlen(fp_m_arlen),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .m_rready(fp_m_rready), .busy(fp_busy), .grant_id(fp_grant_id), .err_len(fp_err_len));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int unsigned m;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    int unsigned ar_delay;
    int unsigned rlast_beat;
    bit          toggle;
    bit          exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] data_fn(input logic [31:0] addr, input int unsigned b);
    return {addr, 32'hA5A5_0000 ^ 32'(b)};
  endfunction

  // Winner = requester at the smallest circular distance at/after the pointer.
  function automatic int unsigned rr_pick(input logic [N-1:0] req, input int unsigned p);
    int unsigned best, bestd, d;
    best = N; bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i + N - p) % N;
      if (req[i] && d < bestd) begin bestd = d; best = i; end
    end
    return best;
  endfunction

  task automatic set_master(input int unsigned m, input logic [31:0] a, input logic [7:0] l,
                            input logic [1:0] b, input logic [2:0] s);
    s_araddr[m*AW +: AW] = a;
    s_arlen[m*8 +: 8]    = l;
    s_arburst[m*2 +: 2]  = b;
    s_arsize[m*3 +: 3]   = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_arvalid = '0; s_rready = '0; m_arready = 1'b0;
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_burst(input int unsigned t, input vec_t v);
    int unsigned acc, cyc, other;
    bit rr;
    string tag;
    tag = $sformatf("vec%0d", t);
    other = (v.m + 1) % N;
    do_reset();
    set_master(v.m, v.addr, v.len, v.burst, v.size);
    set_master(other, 32'h0BAD_0000, 8'd1, INCR, 3'd3);
    s_arvalid = '0;
    s_arvalid[v.m] = 1'b1;
    @(negedge clk);
    check({tag, "_arready"}, 64'(s_arready), 64'(1) << v.m);
    @(posedge clk); #1;
    s_arvalid = '0;
    s_arvalid[other] = 1'b1;
    check({tag, "_grant_id"}, 64'(grant_id), 64'(v.m));
    for (int unsigned i = 0; i <= v.ar_delay; i++) begin
      m_arready = (i == v.ar_delay);
      @(negedge clk);
      check({tag, "_arvalid"}, 64'(m_arvalid), 64'd1);
      check({tag, "_araddr"}, 64'(m_araddr), 64'(v.addr));
      check({tag, "_arlen"}, 64'(m_arlen), 64'(v.len));
      check({tag, "_arburst"}, 64'({m_arburst, m_arsize}), 64'({v.burst, v.size}));
      check({tag, "_arready_addr"}, 64'(s_arready), 64'd0);
      @(posedge clk); #1;
    end
    m_arready = 1'b0;
    acc = 0; cyc = 0;
    while (acc < v.rlast_beat && cyc < 2000) begin
      rr = v.toggle ? (cyc % 2 == 0) : 1'b1;
      s_rready = '1;
      s_rready[v.m] = rr;
      m_rvalid = 1'b1;
      m_rdata  = data_fn(v.addr, acc);
      m_rlast  = (acc + 1 == v.rlast_beat);
      @(negedge clk);
      check({tag, "_rvalid"}, 64'(s_rvalid), 64'(1) << v.m);
      check({tag, "_m_rready"}, 64'(m_rready), 64'(rr));
      check({tag, "_rdata"}, s_rdata, data_fn(v.addr, acc));
      check({tag, "_rlast"}, 64'(s_rlast), 64'(acc + 1 == v.rlast_beat));
      check({tag, "_arready_data"}, 64'(s_arready), 64'd0);
      if (rr) acc++;
      cyc++;
      @(posedge clk); #1;
      if (rr && acc < v.rlast_beat) check({tag, "_busy_mid"}, 64'(busy), 64'd1);
    end
    if (cyc >= 2000) check({tag, "_beat_timeout"}, 64'(acc), 64'(v.rlast_beat));
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_err_len"}, 64'(err_len), 64'(v.exp_err));
  endtask

  vec_t tbl[7];

  logic [N-1:0]  pend;
  logic [31:0]   r_addr[N];
  logic [7:0]    r_len[N];
  logic [1:0]    r_burst[N];
  logic [2:0]    r_size[N];

  initial begin
    int unsigned ptr_m, fl_m, beat, w;
    logic [31:0] fl_addr;
    logic [7:0]  fl_len;
    logic [1:0]  fl_burst;
    logic [2:0]  fl_size;
    logic [N-1:0] exp_ar;
    bit ar_pend, mem_has, acc;

    tbl[0] = '{0, 32'h0000_1000, 8'd3,   INCR,  3'd3, 2, 4,   1'b0, 1'b0};
    tbl[1] = '{1, 32'h0000_2040, 8'd3,   INCR,  3'd3, 0, 4,   1'b1, 1'b0};
    tbl[2] = '{0, 32'h0000_3000, 8'd3,   WRAP,  3'd2, 1, 2,   1'b0, 1'b1};
    tbl[3] = '{2, 32'h0000_4000, 8'd0,   FIXED, 3'd3, 0, 2,   1'b0, 1'b1};
    tbl[4] = '{1, 32'h0000_5000, 8'd255, INCR,  3'd3, 0, 256, 1'b0, 1'b0};
    tbl[5] = '{2, 32'h0000_6000, 8'd255, INCR,  3'd3, 0, 255, 1'b0, 1'b1};
    tbl[6] = '{0, 32'hFFFF_FFF0, 8'd0,   INCR,  3'd0, 3, 1,   1'b0, 1'b0};

    rst = 1'b1;
    s_araddr = '0; s_arlen = '0; s_arburst = '0; s_arsize = '0;
    s_arvalid = '1; s_rready = '1; m_arready = 1'b1;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = '1;
    @(negedge clk);
    check("reset_arready", 64'(s_arready), 64'd0);
    check("reset_busy", 64'({busy, m_arvalid, m_rready, err_len}), 64'd0);
    check("reset_grant_id", 64'(grant_id), 64'd0);
    check("reset_rvalid", 64'({s_rvalid, s_rlast}), 64'd0);
    check("reset_rdata", s_rdata, 64'd0);

    for (int unsigned t = 0; t < 7; t++) run_burst(t, tbl[t]);

    // Contention: masters 0 and 1 request back-to-back single-beat bursts.
    do_reset();
    set_master(0, 32'h0000_A000, 8'd0, INCR, 3'd3);
    set_master(1, 32'h0000_B000, 8'd0, INCR, 3'd3);
    s_arvalid = 3'b011; s_rready = '1; m_arready = 1'b1;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 64'hDEAD_BEEF;
    for (int unsigned k = 0; k < 4; k++) begin
      w = 0;
      @(negedge clk);
      while (s_arready == '0 && w < 6) begin @(negedge clk); w++; end
      if (w >= 6) check("cont_timeout", 64'(w), 64'd0);
      check("rr_arready", 64'(s_arready), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("fp_arready", 64'(fp_s_arready), 64'd1);
      @(posedge clk); #1;
      check("rr_grant_id", 64'(grant_id), 64'(k % 2));
      check("fp_grant_id", 64'(fp_grant_id), 64'd0);
      @(negedge clk);
      check("stray_addr_stall", 64'({m_rready, s_rvalid}), 64'd0);
      check("stray_addr_arvalid", 64'(m_arvalid), 64'd1);
    end

    // Reset in the middle of an 8-beat burst from master 1 (pointer moves to 2).
    do_reset();
    s_rready = '1;
    set_master(1, 32'h0000_C000, 8'd7, INCR, 3'd3);
    set_master(2, 32'h0000_D000, 8'd1, INCR, 3'd3);
    s_arvalid = 3'b010;
    @(negedge clk);
    check("rst_seq_grant", 64'(s_arready), 64'd2);
    @(posedge clk); #1;
    s_arvalid = '0; m_arready = 1'b1;
    @(posedge clk); #1;
    m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = data_fn(32'h0000_C000, 0);
    @(posedge clk); #1;
    m_rdata = data_fn(32'h0000_C000, 1);
    @(posedge clk); #1;
    check("rst_seq_busy", 64'(busy), 64'd1);
    s_arvalid = 3'b110;
    #2 rst = 1'b1;
    #1;
    check("rst_async_ctrl", 64'({busy, m_arvalid, m_rready, err_len, s_rlast}), 64'd0);
    check("rst_async_ports", 64'({s_arready, s_rvalid, grant_id}), 64'd0);
    check("rst_async_ar", 64'({m_araddr, m_arlen}), 64'd0);
    check("rst_async_rdata", s_rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; m_rvalid = 1'b0;
    @(negedge clk);
    check("rst_ptr_zero", 64'(s_arready), 64'd2);

    // Randomized traffic against a transaction-level model.
    do_reset();
    pend = '0; ptr_m = 0; ar_pend = 0; mem_has = 0; beat = 0;
    fl_m = 0; fl_addr = '0; fl_len = '0; fl_burst = '0; fl_size = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(0, 99) < 3) pend[i] = 1'b0;
        else if (!pend[i] && cyc < 2600 && $urandom_range(0, 99) < 30) begin
          pend[i] = 1'b1;
          r_addr[i] = $urandom;
          r_len[i] = 8'($urandom_range(0, 7));
          r_burst[i] = 2'($urandom_range(0, 2));
          r_size[i] = 3'($urandom_range(0, 3));
        end
        set_master(i, r_addr[i], r_len[i], r_burst[i], r_size[i]);
        s_arvalid[i] = pend[i];
        s_rready[i] = ($urandom_range(0, 3) != 0);
      end
      m_arready = ($urandom_range(0, 2) != 0);
      if (mem_has) begin
        m_rvalid = ($urandom_range(0, 3) != 0);
        m_rdata  = data_fn(fl_addr, beat);
        m_rlast  = (beat == int'(fl_len));
      end else begin
        m_rvalid = ($urandom_range(0, 4) == 0);
        m_rdata  = {$urandom, $urandom};
        m_rlast  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      exp_ar = '0;
      if (!ar_pend && !mem_has && s_arvalid != '0) exp_ar[rr_pick(s_arvalid, ptr_m)] = 1'b1;
      check("rnd_arready", 64'(s_arready), 64'(exp_ar));
      check("rnd_busy", 64'(busy), 64'(ar_pend || mem_has));
      check("rnd_arvalid", 64'(m_arvalid), 64'(ar_pend));
      if (ar_pend) check("rnd_ar_fields", {fl_addr, 19'd0, fl_len, fl_burst, fl_size},
                         {m_araddr, 19'd0, m_arlen, m_arburst, m_arsize});
      check("rnd_rvalid", 64'(s_rvalid), mem_has ? (64'(m_rvalid) << fl_m) : 64'd0);
      check("rnd_m_rready", 64'(m_rready), mem_has ? 64'(s_rready[fl_m]) : 64'd0);
      if (mem_has && m_rvalid) begin
        check("rnd_rdata", s_rdata, data_fn(fl_addr, beat));
        check("rnd_rlast", 64'(s_rlast), 64'(beat == int'(fl_len)));
      end
      acc = mem_has && m_rvalid && s_rready[fl_m];
      if (exp_ar != '0) begin
        fl_m = rr_pick(s_arvalid, ptr_m);
        fl_addr = r_addr[fl_m]; fl_len = r_len[fl_m];
        fl_burst = r_burst[fl_m]; fl_size = r_size[fl_m];
        pend[fl_m] = 1'b0; ar_pend = 1'b1;
      end else if (ar_pend && m_arready) begin
        ar_pend = 1'b0; mem_has = 1'b1; beat = 0; ptr_m = (fl_m + 1) % N;
      end else if (acc) begin
        if (beat == int'(fl_len)) mem_has = 1'b0;
        else beat++;
      end
      @(posedge clk); #1;
    end
    check("rnd_final_busy", 64'(busy), 64'd0);
    check("rnd_final_err_len", 64'(err_len), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Parametrised AXI4 read-channel arbiter: NUM_MASTERS read masters (ICache, DCache, later prefetchers) share one memory-side AR/R port.
- One burst in flight at a time. The grant is held from AR accept until the final R beat (rlast).
- Replaces the fixed point-to-point Core–ICache read hookup. Adds round-robin or fixed-priority selection and burst-length protocol checking.

Parameters:
- NUM_MASTERS, 2, number of slave-side request ports (1..8).
- ADDR_W, 32, address width.
- DATA_W, 64, read data width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_arvalid  in  NUM_MASTERS  per-master AR valid.
- s_araddr  in  NUM_MASTERS*ADDR_W  per-master address; master i occupies slice [i*ADDR_W +: ADDR_W].
- s_arburst  in  NUM_MASTERS*2  per-master burst type.
- s_arsize  in  NUM_MASTERS*3  per-master beat size.
- s_arlen  in  NUM_MASTERS*8  per-master beats-1.
- s_arready  out  NUM_MASTERS  per-master AR ready.
- s_rvalid  out  NUM_MASTERS  per-master R valid.
- s_rdata  out  DATA_W  R data, broadcast to all masters.
- s_rlast  out  1  R last, broadcast.
- s_rready  in  NUM_MASTERS  per-master R ready.
- m_arvalid, m_araddr, m_arburst, m_arsize, m_arlen  out  1/ADDR_W/2/3/8  memory-side AR channel.
- m_arready  in  1  memory AR ready.
- m_rvalid, m_rdata, m_rlast  in  1/DATA_W/1  memory R channel.
- m_rready  out  1  memory R ready.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  $clog2(NUM_MASTERS) (min 1)  index of the current owner.
- err_len  out  1  sticky burst-length protocol error.

Behaviour:
- Reset values: all outputs 0. State is IDLE. The round-robin pointer is 0, so master 0 has highest priority.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any s_arvalid is high, select a winner g. Round-robin: first requester at or after pointer, wrapping modulo NUM_MASTERS. Fixed mode: lowest index.
  - In the same cycle: pulse s_arready[g]=1, capture g's AR fields into registers, store grant_id=g, clear beat counter, go to ADDR.
  - s_arready is never high outside IDLE, and never for more than one master.
- ADDR:
  - m_arvalid=1 with the registered fields, starting the cycle after grant (1-cycle AR latency).
  - m_arvalid and fields stay stable until m_arready=1, then go to DATA.
  - Round-robin pointer <= (g+1) mod NUM_MASTERS at the AR handshake.
- DATA:
  - Combinational routing: s_rvalid[g]=m_rvalid; all other s_rvalid=0.
  - m_rready=s_rready[g]; s_rdata=m_rdata; s_rlast=m_rlast.
  - Each beat (m_rvalid & m_rready) increments the 8-bit beat counter.
  - A beat with m_rlast=1 returns to IDLE. New arbitration happens in that IDLE cycle, giving 1 idle cycle between bursts.
- Length check (any beat in DATA):
  - err_len is set if m_rlast=1 and counter != arlen_reg, or if counter == arlen_reg and m_rlast=0.
  - err_len is cleared only by rst.
  - Burst termination still follows m_rlast, never the counter.
- arlen=255 (256 beats): the counter must not wrap before the compare. The compare uses the pre-increment value.
- Simultaneous requests: exactly one grant. Losers keep s_arvalid asserted and are served in later IDLE cycles.
- A master dropping s_arvalid before it is granted: nothing is captured for it.
- Memory R beats arriving in IDLE or ADDR: m_rready=0 and no s_rvalid is asserted (stray data is stalled, never forwarded).
- rst asserted mid-burst: immediate return to IDLE with outputs at reset values. The in-flight burst is abandoned; the memory side is reset with the same rst.
- NUM_MASTERS=1: degenerates to a registered pass-through with 1-cycle AR latency.

Decomposition:
- Shared package axi_pkg: AXI burst-type constants (FIXED=2'b00, INCR=2'b01, WRAP=2'b10), AR/R field width constants, FSM state typedef (IDLE/ADDR/DATA).
- One sub-module, rr_arbiter: NUM_MASTERS request vector + pointer + mode -> one-hot grant and encoded index. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single request: master0 araddr=0x0000_1000, arlen=3, INCR, memory gives m_arready after 2 cycles, 4 beats with rlast on beat 4 -> s_arready[0] pulses once, m_araddr=0x1000 held stable, 4 s_rvalid[0] beats, busy drops the cycle after rlast, err_len=0.
- Round-robin contention: masters 0 and 1 request continuously, arlen=0, ARB_MODE=0 -> grant order 0,1,0,1; grant_id alternates.
- Fixed priority contention: same stimulus with ARB_MODE=1 -> master 0 is granted every burst; master1 is starved while master0 keeps requesting.
- Backpressure: s_rready[g] toggles 1,0,1,0 during a 4-beat burst -> m_rready mirrors it, no beat lost or duplicated, other master's s_rvalid stays 0.
- Length errors:
  - arlen=3 with rlast on beat 2 -> err_len=1, FSM back in IDLE after beat 2.
  - Separately, arlen=0 with no rlast on beat 1 -> err_len=1, FSM stays in DATA until rlast.
- Reset mid-burst: assert rst after beat 2 of 8 -> all outputs 0 asynchronously. After release, master1's new request is served with the pointer back at 0.
